// File: rtl/msu_audio_feeder_pkg.sv
// Shared types and constants for the MSU audio feeder: FSM encoding, buffer
// geometry and the byte lanes of one stereo frame.
package msu_audio_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT,
        ST_FILL,
        ST_DRAIN
    } feeder_state_t;

    localparam int HALF_BYTES = 1024;
    localparam int BUF_BYTES  = 2048;
    localparam int BUF_AW     = 11;
    localparam int CNT_W      = BUF_AW + 1;

    // Frame n occupies buffer bytes 4n..4n+3 in this lane order.
    typedef enum logic [1:0] {
        LANE_L_LO = 2'd0,
        LANE_L_HI = 2'd1,
        LANE_R_LO = 2'd2,
        LANE_R_HI = 2'd3
    } lane_t;

    // The half to refill is the one the DAC just left.
    function automatic logic [BUF_AW-1:0] half_base(input logic dac_in_upper);
        return dac_in_upper ? '0 : BUF_AW'(HALF_BYTES);
    endfunction

endpackage

// File: rtl/msu_stream_addr.sv
// Cartridge read address generator: owns the read pointer and decides when the
// track has run out (loop back or switch to zero padding).
module msu_stream_addr #(
    parameter int MEM_AW = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step,
    input  logic [MEM_AW-1:0] trk_start,
    input  logic [MEM_AW-1:0] trk_end,
    input  logic [MEM_AW-1:0] trk_loop,
    input  logic              rep_r,
    output logic [MEM_AW-1:0] rd_addr,
    output logic              pad
);

    logic [MEM_AW-1:0] rd_addr_reg, rd_addr_next, addr_inc;
    logic              pad_reg, pad_next, loop_ok;

    assign addr_inc = rd_addr_reg + MEM_AW'(1);
    assign loop_ok  = rep_r && (trk_loop < trk_end);

    // The end check is folded into the step so the next request already
    // carries the loop address and no bubble byte appears.
    always_comb begin
        rd_addr_next = rd_addr_reg;
        pad_next     = pad_reg;
        if (load) begin
            rd_addr_next = trk_start;
            pad_next     = (trk_start >= trk_end);
        end else if (step) begin
            if (addr_inc == trk_end && loop_ok) begin
                rd_addr_next = trk_loop;
            end else begin
                rd_addr_next = addr_inc;
                pad_next     = pad_reg || (addr_inc == trk_end);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr_reg <= '0;
            pad_reg     <= 1'b0;
        end else begin
            rd_addr_reg <= rd_addr_next;
            pad_reg     <= pad_next;
        end
    end

    assign rd_addr = rd_addr_reg;
    assign pad     = pad_reg;

endmodule

// File: rtl/msu_audio_feeder.sv
// Streams PCM bytes from cartridge memory into the double-buffered DAC sample
// buffer, tracking the DAC half indicator and gating DAC playback.
module msu_audio_feeder
    import msu_audio_feeder_pkg::*;
#(
    parameter int MEM_AW = 24
) (
    input  logic              clkin,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              repeat_en,
    input  logic [MEM_AW-1:0] trk_start,
    input  logic [MEM_AW-1:0] trk_end,
    input  logic [MEM_AW-1:0] trk_loop,
    input  logic              dac_status,
    output logic              mem_req,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [7:0]        mem_data,
    output logic              pgm_we,
    output logic [BUF_AW-1:0] pgm_address,
    output logic [7:0]        pgm_data,
    output logic              play,
    output logic              playing,
    output logic              underrun
);

    feeder_state_t     state_reg, state_next;
    logic [BUF_AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0]  remain_reg, remain_next;
    logic [BUF_AW-1:0] pgm_address_reg, pgm_address_next;
    logic [7:0]        pgm_data_reg, pgm_data_next;
    logic              pgm_we_reg, pgm_we_next;
    logic              rep_r_reg, rep_r_next;
    logic              play_reg, play_next;
    logic              playing_reg, playing_next;
    logic              underrun_reg, underrun_next;
    logic              status_reg, status_edge;
    logic              addr_load, addr_step, pad, in_xfer, mem_req_c, byte_done;
    logic [MEM_AW-1:0] rd_addr;

    msu_stream_addr #(.MEM_AW(MEM_AW)) u_stream_addr (
        .clk       (clkin),
        .reset     (reset),
        .load      (addr_load),
        .step      (addr_step),
        .trk_start (trk_start),
        .trk_end   (trk_end),
        .trk_loop  (trk_loop),
        .rep_r     (rep_r_reg),
        .rd_addr   (rd_addr),
        .pad       (pad)
    );

    assign status_edge = dac_status ^ status_reg;
    assign in_xfer     = (state_reg == ST_PREFILL) || (state_reg == ST_FILL);
    assign mem_req_c   = in_xfer && (remain_reg != '0) && !pad;

    always_comb begin
        state_next       = state_reg;
        wr_ptr_next      = wr_ptr_reg;
        remain_next      = remain_reg;
        pgm_we_next      = 1'b1;
        pgm_address_next = pgm_address_reg;
        pgm_data_next    = pgm_data_reg;
        rep_r_next       = rep_r_reg;
        play_next        = play_reg;
        playing_next     = playing_reg;
        underrun_next    = underrun_reg;
        addr_load        = 1'b0;
        addr_step        = 1'b0;
        byte_done        = 1'b0;

        if (stop) begin
            state_next   = ST_IDLE;
            play_next    = 1'b0;
            playing_next = 1'b0;
        end else if (start) begin
            state_next    = ST_PREFILL;
            addr_load     = 1'b1;
            wr_ptr_next   = '0;
            remain_next   = CNT_W'(BUF_BYTES);
            rep_r_next    = repeat_en;
            play_next     = 1'b0;
            playing_next  = 1'b1;
            underrun_next = 1'b0;
        end else begin
            case (state_reg)
                ST_PREFILL, ST_FILL: begin
                    if (state_reg == ST_FILL && status_edge) begin
                        underrun_next = 1'b1;
                    end
                    if (pad && remain_reg != '0) begin
                        byte_done     = 1'b1;
                        pgm_data_next = 8'h00;
                    end else if (mem_req_c && mem_ack) begin
                        byte_done     = 1'b1;
                        pgm_data_next = mem_data;
                        addr_step     = 1'b1;
                    end
                    if (byte_done) begin
                        pgm_we_next      = 1'b0;
                        pgm_address_next = wr_ptr_reg;
                        wr_ptr_next      = wr_ptr_reg + BUF_AW'(1);
                        remain_next      = remain_reg - CNT_W'(1);
                        // A fill that had to pad is the last one of the track.
                        if (remain_reg == CNT_W'(1)) begin
                            state_next = pad ? ST_DRAIN : ST_WAIT;
                            if (state_reg == ST_PREFILL) begin
                                play_next = 1'b1;
                            end
                        end
                    end
                end
                ST_WAIT: begin
                    if (status_edge) begin
                        state_next  = ST_FILL;
                        wr_ptr_next = half_base(dac_status);
                        remain_next = CNT_W'(HALF_BYTES);
                    end
                end
                ST_DRAIN: begin
                    if (status_edge) begin
                        state_next   = ST_IDLE;
                        play_next    = 1'b0;
                        playing_next = 1'b0;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge clkin) begin
        if (reset) begin
            wr_ptr_reg      <= '0;
            remain_reg      <= '0;
            pgm_we_reg      <= 1'b1;
            pgm_address_reg <= '0;
            pgm_data_reg    <= '0;
            rep_r_reg       <= 1'b0;
            play_reg        <= 1'b0;
            playing_reg     <= 1'b0;
            underrun_reg    <= 1'b0;
            status_reg      <= 1'b0;
        end else begin
            wr_ptr_reg      <= wr_ptr_next;
            remain_reg      <= remain_next;
            pgm_we_reg      <= pgm_we_next;
            pgm_address_reg <= pgm_address_next;
            pgm_data_reg    <= pgm_data_next;
            rep_r_reg       <= rep_r_next;
            play_reg        <= play_next;
            playing_reg     <= playing_next;
            underrun_reg    <= underrun_next;
            status_reg      <= dac_status;
        end
    end

    assign mem_req     = mem_req_c;
    assign mem_addr    = rd_addr;
    assign pgm_we      = pgm_we_reg;
    assign pgm_address = pgm_address_reg;
    assign pgm_data    = pgm_data_reg;
    assign play        = play_reg;
    assign playing     = playing_reg;
    assign underrun    = underrun_reg;

endmodule
